// File: rtl/tcb_peri_uart_rx.sv
// tcb_peri_uart_rx -- UART receiver with a small receive FIFO and a stream output.
//
// The serial line is synchronized, framed by a two-process FSM, and completed words
// are pushed into a FIFO. The FIFO feeds a valid/ready stream of data plus
// {parity error, framing error} flags.
//
// Optional feature macro: TCB_PERI_UART_RX_PARITY_EN
//   defined   -> a parity bit is received and checked when cfg_par is 01 (even) or 10 (odd)
//   undefined -> cfg_par is ignored, no parity bit is expected, str_err[1] is always 0
module tcb_peri_uart_rx #(
    parameter int unsigned RW = 16,
    parameter int unsigned DW = 8,
    parameter int unsigned FD = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [RW-1:0] cfg_bdr,
    input  logic [RW-1:0] cfg_smp,
    input  logic [3:0]    cfg_len,
    input  logic [1:0]    cfg_par,
    input  logic          cfg_stp,
    output logic          str_vld,
    input  logic          str_rdy,
    output logic [DW-1:0] str_dat,
    output logic [1:0]    str_err,
    output logic          err_ovr,
    input  logic          err_clr,
    input  logic          rxd
);

    localparam int unsigned AW = $clog2(FD);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef TCB_PERI_UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t state_q, state_d;

    logic rxd_meta, rxd_sync, rxd_prev;
    logic rx_fall;

    logic [RW-1:0] cnt_q;
    logic [RW-1:0] bdr_q, smp_q;
    logic [3:0]    len_q;
    logic          stp_q;
    logic [3:0]    bit_cnt_q;
    logic          stop_cnt_q;
    logic [DW-1:0] data_q;
    logic [DW-1:0] bit_vec;
    logic          ferr_q, ferr_d;
    logic          perr_word;

    logic smp_stb, end_stb;
    logic frame_start, push_req;

`ifdef TCB_PERI_UART_RX_PARITY_EN
    logic [1:0] par_q;
    logic       perr_q;
    logic       par_en;
    logic       par_exp;
`else
    logic       cfg_par_unused;
`endif

    logic [AW:0]   wr_ptr, rd_ptr;
    logic          fifo_empty, fifo_full;
    logic          pop, push_ok, ovr_set;
    logic [DW+1:0] mem [FD];
    logic [DW+1:0] rd_word;

    // Two-flop synchronizer for the asynchronous line, plus a delayed copy for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_sync <= rxd_meta;
            rxd_prev <= rxd_sync;
        end
    end

    assign rx_fall = rxd_prev & ~rxd_sync;

    // Strobes derived from the per-frame latched baud configuration
    assign smp_stb = (cnt_q == smp_q);
    assign end_stb = (cnt_q == bdr_q);
    assign bit_vec = {{(DW-1){1'b0}}, rxd_sync};

    // Framing error includes the stop sample taken in the current cycle
    assign ferr_d = ferr_q | ~rxd_sync;

`ifdef TCB_PERI_UART_RX_PARITY_EN
    assign par_en    = (par_q == 2'b01) || (par_q == 2'b10);
    assign par_exp   = (par_q == 2'b10) ? ~(^data_q) : (^data_q);
    assign perr_word = perr_q;
`else
    assign cfg_par_unused = ^cfg_par;
    assign perr_word      = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; the last stop sample pushes the word and returns to IDLE at once
    always_comb begin
        state_d     = state_q;
        frame_start = 1'b0;
        push_req    = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_fall) begin
                    state_d     = START;
                    frame_start = 1'b1;
                end
            end
            START: begin
                if (smp_stb && rxd_sync) begin
                    state_d = IDLE;
                end else if (end_stb) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (smp_stb && (bit_cnt_q == (len_q - 4'd1))) begin
`ifdef TCB_PERI_UART_RX_PARITY_EN
                    state_d = par_en ? PARITY : STOP;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef TCB_PERI_UART_RX_PARITY_EN
            PARITY: begin
                if (smp_stb) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (smp_stb && (stop_cnt_q == stp_q)) begin
                    state_d  = IDLE;
                    push_req = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Frame datapath: config capture at frame start, baud counter, bit shifting and error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            bdr_q      <= '0;
            smp_q      <= '0;
            len_q      <= '0;
            stp_q      <= 1'b0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            data_q     <= '0;
            ferr_q     <= 1'b0;
`ifdef TCB_PERI_UART_RX_PARITY_EN
            par_q      <= '0;
            perr_q     <= 1'b0;
`endif
        end else if (frame_start) begin
            cnt_q      <= '0;
            bdr_q      <= cfg_bdr;
            smp_q      <= cfg_smp;
            len_q      <= cfg_len;
            stp_q      <= cfg_stp;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            data_q     <= '0;
            ferr_q     <= 1'b0;
`ifdef TCB_PERI_UART_RX_PARITY_EN
            par_q      <= cfg_par;
            perr_q     <= 1'b0;
`endif
        end else if (state_q != IDLE) begin
            cnt_q <= end_stb ? '0 : cnt_q + 1'b1;
            if (smp_stb) begin
                case (state_q)
                    DATA: begin
                        data_q    <= data_q | (bit_vec << bit_cnt_q);
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                    end
`ifdef TCB_PERI_UART_RX_PARITY_EN
                    PARITY: begin
                        perr_q <= rxd_sync ^ par_exp;
                    end
`endif
                    STOP: begin
                        ferr_q     <= ferr_d;
                        stop_cnt_q <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // FIFO status; an extra pointer bit separates full from empty
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop        = str_vld & str_rdy;
    assign push_ok    = push_req & (~fifo_full | pop);
    assign ovr_set    = push_req & fifo_full & ~pop;

    // FIFO pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // FIFO storage is not reset; its contents only matter while str_vld is high
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= {perr_word, ferr_d, data_q};
        end
    end

    // Sticky overrun flag; a new overrun wins over a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_ovr <= 1'b0;
        end else if (ovr_set) begin
            err_ovr <= 1'b1;
        end else if (err_clr) begin
            err_ovr <= 1'b0;
        end
    end

    assign rd_word = mem[rd_ptr[AW-1:0]];
    assign str_vld = ~fifo_empty;
    assign str_dat = rd_word[DW-1:0];
    assign str_err = rd_word[DW+1:DW];

endmodule
